// File: rtl/rv32_id_ex_operand_stage_if.sv
// rv32_id_ex_operand_stage_if: ID-side capture fields, bypass sources and EX-side operand outputs.
interface rv32_id_ex_operand_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [3:0]            id_alu_opsel;
  logic                  id_use_imm;
  logic                  id_use_pc;
  logic                  id_reg_write;
  logic                  stall;
  logic                  flush;
  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_rd_addr;
  logic [XLEN-1:0]       exmem_result;
  logic                  memwb_reg_write;
  logic [REG_ADDR_W-1:0] memwb_rd_addr;
  logic [XLEN-1:0]       memwb_result;
  logic                  ex_valid;
  logic [XLEN-1:0]       ex_opA;
  logic [XLEN-1:0]       ex_opB;
  logic [3:0]            ex_alu_opsel;
  logic [XLEN-1:0]       ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write;
  logic [XLEN-1:0]       ex_pc;
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_alu_opsel, id_use_imm, id_use_pc, id_reg_write, stall, flush,
           exmem_reg_write, exmem_rd_addr, exmem_result, memwb_reg_write, memwb_rd_addr,
           memwb_result,
    input  ex_valid, ex_opA, ex_opB, ex_alu_opsel, ex_store_data, ex_rd_addr, ex_reg_write, ex_pc
  );
  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_alu_opsel, id_use_imm, id_use_pc, id_reg_write, stall, flush,
           exmem_reg_write, exmem_rd_addr, exmem_result, memwb_reg_write, memwb_rd_addr,
           memwb_result,
    output ex_valid, ex_opA, ex_opB, ex_alu_opsel, ex_store_data, ex_rd_addr, ex_reg_write, ex_pc
  );
endinterface

// File: rtl/rv32_id_ex_operand_stage.sv
// rv32_id_ex_operand_stage: ID/EX register with stall/flush, EX/MEM + MEM/WB bypass and operand select.
module rv32_id_ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic clk,
  input logic rst_n,
  rv32_id_ex_operand_stage_if.slave bus
);
  logic                  valid_q, valid_d, reg_write_q, reg_write_d;
  logic                  use_imm_q, use_imm_d, use_pc_q, use_pc_d;
  logic [XLEN-1:0]       pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
  logic [3:0]            opsel_q, opsel_d;
  logic                  mw1_hit, mw2_hit, em1_hit, em2_hit;
  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;
  assign em1_hit = bus.exmem_reg_write && bus.exmem_rd_addr != '0 && bus.exmem_rd_addr == rs1_addr_q;
  assign em2_hit = bus.exmem_reg_write && bus.exmem_rd_addr != '0 && bus.exmem_rd_addr == rs2_addr_q;
  assign mw1_hit = bus.memwb_reg_write && bus.memwb_rd_addr != '0 && bus.memwb_rd_addr == rs1_addr_q;
  assign mw2_hit = bus.memwb_reg_write && bus.memwb_rd_addr != '0 && bus.memwb_rd_addr == rs2_addr_q;
  assign fwd_rs1 = em1_hit ? bus.exmem_result : mw1_hit ? bus.memwb_result : rs1_q;
  assign fwd_rs2 = em2_hit ? bus.exmem_result : mw2_hit ? bus.memwb_result : rs2_q;
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    use_imm_d   = use_imm_q;
    use_pc_d    = use_pc_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    opsel_d     = opsel_q;
    if (bus.flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      opsel_d     = '0;
      rd_addr_d   = '0;
    end else if (!bus.stall) begin
      valid_d     = bus.id_valid;
      reg_write_d = bus.id_reg_write;
      use_imm_d   = bus.id_use_imm;
      use_pc_d    = bus.id_use_pc;
      pc_d        = bus.id_pc;
      rs1_d       = bus.id_rs1_data;
      rs2_d       = bus.id_rs2_data;
      imm_d       = bus.id_imm;
      rs1_addr_d  = bus.id_rs1_addr;
      rs2_addr_d  = bus.id_rs2_addr;
      rd_addr_d   = bus.id_rd_addr;
      opsel_d     = bus.id_alu_opsel;
    end else begin
      // a value retiring while we are held would otherwise vanish before the stall lifts
      rs1_d = mw1_hit ? bus.memwb_result : rs1_q;
      rs2_d = mw2_hit ? bus.memwb_result : rs2_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      opsel_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      use_imm_q   <= use_imm_d;
      use_pc_q    <= use_pc_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      opsel_q     <= opsel_d;
    end
  end
  assign bus.ex_valid      = valid_q;
  assign bus.ex_opA        = !valid_q ? '0 : use_pc_q ? pc_q : fwd_rs1;
  assign bus.ex_opB        = !valid_q ? '0 : use_imm_q ? imm_q : fwd_rs2;
  assign bus.ex_store_data = valid_q ? fwd_rs2 : '0;
  assign bus.ex_alu_opsel  = valid_q ? opsel_q : 4'd0;
  assign bus.ex_reg_write  = valid_q & reg_write_q;
  assign bus.ex_rd_addr    = rd_addr_q;
  assign bus.ex_pc         = pc_q;
endmodule

// File: tb/tb_rv32_id_ex_operand_stage.sv
// tb_rv32_id_ex_operand_stage: directed test-plan scenarios plus random traffic against a behavioural model.
module tb_rv32_id_ex_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rv32_id_ex_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
  rv32_id_ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    bit          valid, rw, ui, up;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  a1, a2, rd;
    logic [3:0]  opsel;
  } ex_t;
  ex_t m;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (bus.exmem_reg_write && bus.exmem_rd_addr != 0 && bus.exmem_rd_addr == a) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd_addr != 0 && bus.memwb_rd_addr == a) return bus.memwb_result;
    return d;
  endfunction
  task automatic check_model(input string tag);
    logic [31:0] f1, f2;
    f1 = fwd(m.a1, m.rs1);
    f2 = fwd(m.a2, m.rs2);
    chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(m.valid));
    chk({tag, ".opA"}, bus.ex_opA, !m.valid ? 0 : m.up ? m.pc : f1);
    chk({tag, ".opB"}, bus.ex_opB, !m.valid ? 0 : m.ui ? m.imm : f2);
    chk({tag, ".store"}, bus.ex_store_data, m.valid ? f2 : 0);
    chk({tag, ".opsel"}, 32'(bus.ex_alu_opsel), m.valid ? 32'(m.opsel) : 0);
    chk({tag, ".rw"}, 32'(bus.ex_reg_write), 32'(m.valid && m.rw));
    chk({tag, ".rd"}, 32'(bus.ex_rd_addr), 32'(m.rd));
    chk({tag, ".pc"}, bus.ex_pc, m.pc);
  endtask
  task automatic clear_model();
    m = '{valid: 0, rw: 0, ui: 0, up: 0, pc: 0, rs1: 0, rs2: 0, imm: 0, a1: 0, a2: 0, rd: 0, opsel: 0};
  endtask
  task automatic tick();
    @(posedge clk);
    if (bus.flush) begin
      m.valid = 0; m.rw = 0; m.opsel = 0; m.rd = 0;
    end else if (!bus.stall) begin
      m.valid = bus.id_valid; m.rw = bus.id_reg_write; m.ui = bus.id_use_imm; m.up = bus.id_use_pc;
      m.pc = bus.id_pc; m.rs1 = bus.id_rs1_data; m.rs2 = bus.id_rs2_data; m.imm = bus.id_imm;
      m.a1 = bus.id_rs1_addr; m.a2 = bus.id_rs2_addr; m.rd = bus.id_rd_addr; m.opsel = bus.id_alu_opsel;
    end else if (bus.memwb_reg_write && bus.memwb_rd_addr != 0) begin
      if (bus.memwb_rd_addr == m.a1) m.rs1 = bus.memwb_result;
      if (bus.memwb_rd_addr == m.a2) m.rs2 = bus.memwb_result;
    end
    @(negedge clk);
  endtask
  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
    bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0; bus.id_alu_opsel = 0;
    bus.id_use_imm = 0; bus.id_use_pc = 0; bus.id_reg_write = 0; bus.stall = 0; bus.flush = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd_addr = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd_addr = 0; bus.memwb_result = 0;
  endtask
  task automatic random_inputs();
    bus.id_valid = $urandom_range(0, 4) != 0; bus.id_pc = $urandom; bus.id_rs1_data = $urandom;
    bus.id_rs2_data = $urandom; bus.id_imm = $urandom; bus.id_rs1_addr = 5'($urandom_range(0, 7));
    bus.id_rs2_addr = 5'($urandom_range(0, 7)); bus.id_rd_addr = 5'($urandom_range(0, 31));
    bus.id_alu_opsel = 4'($urandom); bus.id_use_imm = 1'($urandom); bus.id_use_pc = 1'($urandom);
    bus.id_reg_write = 1'($urandom); bus.stall = $urandom_range(0, 3) == 0;
    bus.flush = $urandom_range(0, 7) == 0; bus.exmem_reg_write = 1'($urandom);
    bus.exmem_rd_addr = 5'($urandom_range(0, 7)); bus.exmem_result = $urandom;
    bus.memwb_reg_write = 1'($urandom); bus.memwb_rd_addr = 5'($urandom_range(0, 7));
    bus.memwb_result = $urandom;
  endtask
  initial begin
    clear_inputs();
    clear_model();
    #12;
    check_model("por");
    @(negedge clk);
    rst_n = 1;
    bus.id_valid = 1; bus.id_rs1_data = 32'hF0F0F0F0; bus.id_rs2_data = 32'h0FF00FF0;
    bus.id_alu_opsel = 4'd2; bus.id_rs1_addr = 1; bus.id_rs2_addr = 2; bus.id_rd_addr = 3;
    bus.id_reg_write = 1; bus.id_pc = 32'h100;
    tick();
    #1;
    chk("pass.opA", bus.ex_opA, 32'hF0F0F0F0);
    chk("pass.opB", bus.ex_opB, 32'h0FF00FF0);
    chk("pass.opsel", 32'(bus.ex_alu_opsel), 2);
    chk("pass.valid", 32'(bus.ex_valid), 1);
    check_model("pass");
    #1 rst_n = 0;
    #1;
    clear_model();
    chk("arst.valid", 32'(bus.ex_valid), 0);
    chk("arst.opA", bus.ex_opA, 0);
    chk("arst.rw", 32'(bus.ex_reg_write), 0);
    chk("arst.pc", bus.ex_pc, 0);
    check_model("arst");
    @(negedge clk);
    rst_n = 1;
    bus.id_rs1_addr = 5;
    tick();
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 5; bus.exmem_result = 32'h11;
    bus.memwb_reg_write = 1; bus.memwb_rd_addr = 5; bus.memwb_result = 32'h22;
    #1 chk("fwd.exmem", bus.ex_opA, 32'h11);
    check_model("fwd.exmem");
    bus.exmem_reg_write = 0;
    #1 chk("fwd.memwb", bus.ex_opA, 32'h22);
    check_model("fwd.memwb");
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 0; bus.memwb_rd_addr = 0;
    bus.id_rs1_addr = 0; bus.id_rs1_data = 32'h99;
    tick();
    #1 chk("fwd.x0", bus.ex_opA, 32'h99);
    check_model("fwd.x0");
    bus.id_use_imm = 1; bus.id_imm = 32'hFFFFF800; bus.id_rs2_addr = 9; bus.id_rs2_data = 0;
    tick();
    bus.exmem_rd_addr = 9; bus.exmem_result = 32'hABCD;
    #1 chk("imm.opB", bus.ex_opB, 32'hFFFFF800);
    chk("imm.store", bus.ex_store_data, 32'hABCD);
    check_model("imm");
    bus.exmem_reg_write = 0; bus.memwb_reg_write = 0;
    bus.id_use_imm = 0; bus.id_rs2_addr = 7; bus.id_rs2_data = 32'h5555;
    tick();
    bus.stall = 1; bus.memwb_reg_write = 1; bus.memwb_rd_addr = 7; bus.memwb_result = 32'h1234;
    bus.id_rs2_data = 32'hBAD0BAD0; bus.id_rs2_addr = 3;
    tick();
    bus.memwb_rd_addr = 8; bus.memwb_result = 32'hDEAD;
    tick();
    bus.stall = 0; bus.memwb_reg_write = 0;
    #1 chk("stall.opB", bus.ex_opB, 32'h1234);
    check_model("stall");
    bus.flush = 1; bus.stall = 1;
    tick();
    #1 chk("flush.valid", 32'(bus.ex_valid), 0);
    chk("flush.rw", 32'(bus.ex_reg_write), 0);
    chk("flush.opA", bus.ex_opA, 0);
    chk("flush.opB", bus.ex_opB, 0);
    chk("flush.opsel", 32'(bus.ex_alu_opsel), 0);
    check_model("flush");
    for (int i = 0; i < 500; i++) begin
      random_inputs();
      #1 check_model("rand");
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
